// File: rtl/r_write_arbiter.sv
// r_write_arbiter: round-robin arbiter for the single write port of accumulator R.
// Ports: clk, rst (async, active-high); reqInbox/reqMem/reqData/reqAlu are held until their
// ackInbox/ackMem/ackData/ackAlu pulse; hold blocks new grants; muxR/wR drive R's write port;
// memRd strobes a memory read; busy is high while a memory load waits out MEM_LAT.
module r_write_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reqInbox,
    input  logic       reqMem,
    input  logic       reqData,
    input  logic       reqAlu,
    input  logic       hold,
    output logic       ackInbox,
    output logic       ackMem,
    output logic       ackData,
    output logic       ackAlu,
    output logic [1:0] muxR,
    output logic       wR,
    output logic       memRd,
    output logic       busy
);
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
        $error("MEM_LAT must be in 1..15");
    end
    typedef enum logic {IDLE, MEMWAIT} state_t;
    state_t     state;
    logic [1:0] ptr, off, g;
    logic [3:0] cnt, ack, elig;
    // a source whose ack is already high is still asserting its req this cycle; skip it
    assign elig = {reqAlu, reqData, reqMem, reqInbox} & ~ack;
    // off is the distance from ptr to the first eligible source, scanning ptr, ptr+1, ...
    always_comb begin
        off = 2'd0;
        for (int i = 3; i >= 0; i--) if (elig[2'(ptr + 2'(i))]) off = 2'(i);
    end
    assign g = ptr + off;
    assign {ackAlu, ackData, ackMem, ackInbox} = ack;
    assign busy = state == MEMWAIT;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            wR    <= 1'b0;
            muxR  <= 2'd0;
            ack   <= 4'd0;
            memRd <= 1'b0;
        end else begin
            wR    <= 1'b0;
            ack   <= 4'd0;
            memRd <= 1'b0;
            if (state == MEMWAIT) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    wR    <= 1'b1;
                    muxR  <= 2'd1;
                    ack   <= 4'b0010;
                    state <= IDLE;
                end
            end else if (!hold && |elig) begin
                if (g == 2'd1) begin
                    memRd <= 1'b1;
                    cnt   <= 4'(MEM_LAT);
                    ptr   <= 2'd2;
                    state <= MEMWAIT;
                end else begin
                    wR   <= 1'b1;
                    muxR <= g;
                    ack  <= 4'b0001 << g;
                    ptr  <= g + 2'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_r_write_arbiter.sv
// tb_r_write_arbiter: directed and randomized checks of r_write_arbiter against a behavioural model.
module tb_r_write_arbiter;
    localparam int LAT = 2;
    logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
    logic reqInbox = 1'b0, reqMem = 1'b0, reqData = 1'b0, reqAlu = 1'b0;
    logic ackInbox, ackMem, ackData, ackAlu, wR, memRd, busy;
    logic [1:0] muxR;
    logic ackInbox3, ackMem3, ackData3, ackAlu3, wR3, memRd3, busy3;
    logic [1:0] muxR3;
    logic [8:0] outs, outs3;
    int total = 0, bad = 0;
    int m_ptr, m_wait;
    logic [3:0] e_ack;
    logic [1:0] e_mux;
    logic e_w, e_rd, e_busy;
    logic [8:0] e_vec;
    always #5 clk = ~clk;
    r_write_arbiter #(.MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .reqInbox(reqInbox), .reqMem(reqMem), .reqData(reqData),
        .reqAlu(reqAlu), .hold(hold), .ackInbox(ackInbox), .ackMem(ackMem), .ackData(ackData),
        .ackAlu(ackAlu), .muxR(muxR), .wR(wR), .memRd(memRd), .busy(busy)
    );
    r_write_arbiter #(.MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .reqInbox(reqInbox), .reqMem(reqMem), .reqData(reqData),
        .reqAlu(reqAlu), .hold(hold), .ackInbox(ackInbox3), .ackMem(ackMem3), .ackData(ackData3),
        .ackAlu(ackAlu3), .muxR(muxR3), .wR(wR3), .memRd(memRd3), .busy(busy3)
    );
    // {muxR, wR, memRd, busy, ackAlu, ackData, ackMem, ackInbox}
    assign outs  = {muxR, wR, memRd, busy, ackAlu, ackData, ackMem, ackInbox};
    assign outs3 = {muxR3, wR3, memRd3, busy3, ackAlu3, ackData3, ackMem3, ackInbox3};
    assign e_vec = {e_mux, e_w, e_rd, e_busy, e_ack};

    task automatic model_reset();
        m_ptr = 0; m_wait = 0; e_ack = 4'd0; e_mux = 2'd0; e_w = 1'b0; e_rd = 1'b0; e_busy = 1'b0;
    endtask

    // One clock: the model consumes the inputs present at the edge, then outputs settle.
    task automatic tick();
        logic [3:0] r, pa;
        bit done;
        @(posedge clk);
        r = {reqAlu, reqData, reqMem, reqInbox};
        pa = e_ack;
        e_w = 1'b0; e_rd = 1'b0; e_ack = 4'd0; done = 0;
        if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                e_w = 1'b1; e_mux = 2'd1; e_ack = 4'b0010;
            end
        end else if (!hold) begin
            for (int k = 0; k < 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (!done && r[i] && !pa[i]) begin
                    done = 1;
                    if (i == 1) begin
                        e_rd = 1'b1; m_wait = LAT; m_ptr = 2;
                    end else begin
                        e_w = 1'b1; e_mux = 2'(i); e_ack[i] = 1'b1; m_ptr = (i + 1) % 4;
                    end
                end
            end
        end
        e_busy = m_wait > 0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {reqAlu, reqData, reqMem, reqInbox} = 4'd0;
        hold = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        reqAlu = 1'b1;
        tick();
        reqAlu = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (outs !== 9'd0) begin bad++; $display("FAIL reset_async got=%b want=%b", outs, 9'd0); end
        #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            tick();
            total++;
            if (outs !== 9'd0) begin bad++; $display("FAIL reset_idle n=%0d got=%b want=%b", n, outs, 9'd0); end
        end
    endtask

    task automatic test_single_alu();
        do_reset();
        reqAlu = 1'b1;
        tick();
        reqAlu = 1'b0;
        total++;
        if (outs !== 9'b11_1_0_0_1000) begin bad++; $display("FAIL single_alu got=%b want=%b", outs, 9'b11_1_0_0_1000); end
        for (int n = 2; n < 5; n++) begin
            tick();
            total++;
            if (outs !== 9'b11_0_0_0_0000) begin bad++; $display("FAIL single_alu_after c=%0d got=%b want=%b", n, outs, 9'b11_0_0_0_0000); end
        end
    endtask

    task automatic test_all_four();
        logic [8:0] exp_tab [1:8];
        logic [3:0] pa;
        exp_tab[1] = 9'b00_1_0_0_0001;
        exp_tab[2] = 9'b00_0_1_1_0000;
        exp_tab[3] = 9'b00_0_0_1_0000;
        exp_tab[4] = 9'b01_1_0_0_0010;
        exp_tab[5] = 9'b10_1_0_0_0100;
        exp_tab[6] = 9'b11_1_0_0_1000;
        exp_tab[7] = 9'b00_1_0_0_0001;
        exp_tab[8] = 9'b00_0_1_1_0000;
        do_reset();
        {reqAlu, reqData, reqMem, reqInbox} = 4'hf;
        pa = 4'd0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            total++;
            if (outs !== exp_tab[n]) begin bad++; $display("FAIL all_four c=%0d got=%b want=%b", n, outs, exp_tab[n]); end
            {reqAlu, reqData, reqMem, reqInbox} = ~pa;
            pa = {ackAlu, ackData, ackMem, ackInbox};
        end
        {reqAlu, reqData, reqMem, reqInbox} = 4'd0;
    endtask

    task automatic test_lone_data();
        logic [8:0] want;
        do_reset();
        reqData = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            want = (n % 2 == 1) ? 9'b10_1_0_0_0100 : 9'b10_0_0_0_0000;
            total++;
            if (outs !== want) begin bad++; $display("FAIL lone_data c=%0d got=%b want=%b", n, outs, want); end
        end
        reqData = 1'b0;
    endtask

    task automatic test_hold();
        do_reset();
        reqInbox = 1'b1;
        hold = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            tick();
            total++;
            if (wR !== 1'b0) begin bad++; $display("FAIL hold_block c=%0d got=%b want=0", n, wR); end
            if (n == 5) hold = 1'b0;
        end
        tick();
        total++;
        if (outs !== 9'b00_1_0_0_0001) begin bad++; $display("FAIL hold_release got=%b want=%b", outs, 9'b00_1_0_0_0001); end
        reqInbox = 1'b0;
    endtask

    task automatic test_hold_memwait();
        logic [8:0] exp_tab [1:3];
        exp_tab[1] = 9'b00_0_1_1_0000;
        exp_tab[2] = 9'b00_0_0_1_0000;
        exp_tab[3] = 9'b01_1_0_0_0010;
        do_reset();
        reqMem = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            hold = 1'b1;
            reqMem = 1'b0;
            total++;
            if (outs !== exp_tab[n]) begin bad++; $display("FAIL hold_memwait c=%0d got=%b want=%b", n, outs, exp_tab[n]); end
        end
        hold = 1'b0;
    endtask

    task automatic test_mem_reset();
        logic [8:0] exp_tab [3:6];
        exp_tab[3] = 9'b00_0_1_1_0000;
        exp_tab[4] = 9'b00_0_0_1_0000;
        exp_tab[5] = 9'b00_0_0_1_0000;
        exp_tab[6] = 9'b01_1_0_0_0010;
        do_reset();
        reqMem = 1'b1;
        tick();
        total++;
        if (outs3 !== 9'b00_0_1_1_0000) begin bad++; $display("FAIL memrst_rd got=%b want=%b", outs3, 9'b00_0_1_1_0000); end
        tick();
        rst = 1'b1;
        #1;
        total++;
        if (outs3 !== 9'd0) begin bad++; $display("FAIL memrst_abort got=%b want=%b", outs3, 9'd0); end
        #1;
        rst = 1'b0;
        for (int n = 3; n <= 6; n++) begin
            tick();
            total++;
            if (outs3 !== exp_tab[n]) begin bad++; $display("FAIL memrst_restart c=%0d got=%b want=%b", n, outs3, exp_tab[n]); end
        end
        reqMem = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] r;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            tick();
            total++;
            if (outs !== e_vec) begin bad++; $display("FAIL random c=%0d got=%b want=%b", n, outs, e_vec); end
            r = {reqAlu, reqData, reqMem, reqInbox};
            for (int i = 0; i < 4; i++) begin
                if (r[i]) begin
                    if (e_ack[i] ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0)) r[i] = 1'b0;
                end else if ($urandom_range(2) == 0) r[i] = 1'b1;
            end
            {reqAlu, reqData, reqMem, reqInbox} = r;
            hold = $urandom_range(4) == 0;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_alu();
        test_all_four();
        test_lone_data();
        test_hold();
        test_hold_memwait();
        test_mem_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/r_write_arbiter.md
# r_write_arbiter

Write-port controller for the accumulator register R. It shares R's single write port among four requesters: inbox, memory load, immediate data and ALU result. It uses round-robin arbitration and drives R's `muxR`/`wR` controls directly. Memory loads are sequenced through a fixed-latency wait so that `wR` lands on the cycle the memory data is valid.

## Interface
Parameters
- `MEM_LAT`, default 1: memory read latency in cycles from the `memRd` pulse to valid `iMem`. Legal range is 1..15; any other value is an elaboration error.

Ports
- `clk`  in  1  clock. Everything samples on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `reqInbox`, `reqMem`, `reqData`, `reqAlu`  in  1 each  write requests. Each is held high until the matching ack.
- `hold`  in  1  while high, no new grants are issued. A memory wait already in progress continues.
- `ackInbox`, `ackMem`, `ackData`, `ackAlu`  out  1 each  one-cycle pulse, coincident with the `wR` for that source.
- `muxR`  out  2  R source select: 00 inbox, 01 mem, 10 data, 11 alu.
- `wR`  out  1  R write enable, one-cycle pulse.
- `memRd`  out  1  one-cycle memory read strobe.
- `busy`  out  1  high while in MEMWAIT.

## Operation
- Source index equals its `muxR` code: inbox 0, mem 1, data 2, alu 3.
- Round-robin pointer `ptr` (2 bits) names the highest-priority index. Priority runs `ptr`, `ptr+1`, … mod 4.
- A requester is eligible when its req is high and its ack is not currently high. This exclusion prevents double-granting a req that is still asserted in its ack cycle.
- FSM states:
  - IDLE: if `hold`=0 and any requester is eligible, the winner g is chosen.
    - g≠mem: register `wR`=1, `muxR`=g, `ack[g]`=1, `ptr`=g+1. Stay in IDLE.
    - g=mem: register `memRd`=1, `cnt`=`MEM_LAT`, `ptr`=2. Go to MEMWAIT.
  - MEMWAIT: no grants, regardless of requests or `hold`. `cnt` decrements each cycle. On the edge where `cnt`=1, register `wR`=1, `muxR`=01, `ackMem`=1, and return to IDLE.
- All outputs are registered except `busy`, which is decoded from the state register.
- `wR`, all acks and `memRd` default to 0 every cycle unless set as above.
- `muxR` holds its last value while `wR`=0.
- Reset (async, any state, including MEMWAIT):
  - state=IDLE, `ptr`=0, `cnt`=0.
  - `wR`=0, `muxR`=00, all acks=0, `memRd`=0, `busy`=0.
  - An aborted memory load produces no `wR` and no `ackMem`.
- Deasserting a req before its ack withdraws it with no side effects. The one exception is `reqMem` after `memRd` has issued: the load completes anyway.

## Timing
- Non-mem grant: req eligible in cycle t → `wR`/ack high in cycle t+1. R captures at the end of t+1.
- Mem grant: eligible in t → `memRd` high in t+1 → `wR`/`ackMem` high in t+1+`MEM_LAT`. `busy` is high for cycles t+1 … t+`MEM_LAT`.
- Peak throughput is one write per cycle across different sources.
- A single requester holding its req continuously is granted every other cycle, because of the ack-cycle exclusion.
- Grants may issue in the same cycle that `ackMem`/`wR` for a completed load is high, since state is already IDLE.
- `hold` sampled high in cycle t blocks a grant that would otherwise appear in t+1.

## Test plan
- Reset: assert `rst` mid-cycle with no clock edge → all outputs 0 and `muxR`=00 immediately. Release, with no reqs → outputs stay 0.
- Single ALU write: `reqAlu`=1 in cycle 0, dropped on ack → cycle 1 has `wR`=1, `muxR`=11, `ackAlu`=1. No further `wR`.
- All four reqs held, `MEM_LAT`=2, each dropped one cycle after its ack and re-raised after that. Required sequence:
  - inbox `wR` in cycle 1;
  - `memRd` in cycle 2, `busy` in cycles 2–3;
  - mem `wR`/`ackMem` in cycle 4;
  - data in 5, alu in 6, inbox in 7, `memRd` in 8.
- Continuous lone `reqData` → `wR`/`ackData` with `muxR`=10 in cycles 1, 3, 5, …
- `hold`: `reqInbox` held with `hold`=1 for cycles 0–4 → no `wR`. `hold`=0 in cycle 5 → `wR`, `muxR`=00 in cycle 6.
  - `hold`=1 during MEMWAIT → mem `wR` still occurs at t+1+`MEM_LAT`.
- Reset in MEMWAIT: `MEM_LAT`=3, `memRd` in cycle 1, `rst` pulsed in cycle 2 → `busy`=0 at once, no `wR`/`ackMem` in cycle 4.
  - With `reqMem` still high after reset release, the arbiter restarts from `ptr`=0 and issues `memRd` again.
